fir_out_buffer: RTL and testbench
=================================

Name: fir_out_buffer

Overview:
- Output stage placed directly downstream of the 4-tap FIR filter.
- Captures each valid filtered sample (DIN/VIN driven from the filter's DOUT/VOUT) into a first-word-fall-through FIFO.
- Presents samples to the consumer (data sink or next processing stage) with a valid/ready handshake, so the filter runs freely while the consumer stalls.
- Detects and counts samples lost when the buffer is full.

Parameters:
- DW, 16, sample width in bits (signed two's complement).
- DEPTH, 8, FIFO entries; power of 2, minimum 2.
- AW, 3, pointer width; must equal log2(DEPTH).
- CW, 8, width of the drop counter.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous active-high reset.
- DIN  in  DW  sample from filter output.
- VIN  in  1  DIN valid for this cycle (filter VOUT).
- DOUT  out  DW  head-of-FIFO sample.
- VOUT  out  1  DOUT valid.
- RDY_IN  in  1  consumer ready; a sample transfers when VOUT and RDY_IN are both 1.
- CLR_OVF  in  1  synchronous clear of OVF and DROP_CNT.
- FULL  out  1  level equals DEPTH.
- EMPTY  out  1  level equals 0.
- LEVEL  out  AW+1  number of stored entries, 0..DEPTH.
- OVF  out  1  sticky overflow flag.
- DROP_CNT  out  CW  count of dropped samples, saturating.

Behaviour:
- Reset (asynchronous, RST=1):
  - write and read pointers = 0, LEVEL=0, EMPTY=1, FULL=0, VOUT=0, DOUT=0, OVF=0, DROP_CNT=0.
  - Asserting RST mid-operation discards all stored samples immediately.
  - First push is accepted on the first rising edge after RST deasserts.
- Control signals:
  - pop = VOUT & RDY_IN.
  - push = VIN & (~FULL | pop). When full, a simultaneous pop frees the slot, so the push is accepted.
  - drop = VIN & FULL & ~pop.
- Write: on push, mem[wr_ptr] <= DIN and wr_ptr increments.
- Read: on pop, rd_ptr increments.
- Pointers wrap modulo DEPTH.
- LEVEL update: +1 on push only, -1 on pop only, unchanged on both or neither.
- FWFT output:
  - VOUT = ~EMPTY.
  - DOUT = mem[rd_ptr] when VOUT=1, else 0 (combinational from registered state).
- Latency: a sample pushed at edge N is visible on DOUT/VOUT after edge N, with zero-wait pass-through from an empty buffer.
- Simultaneous push and pop with EMPTY=1 cannot occur, because pop requires VOUT; the push is stored.
- Handshake rules:
  - DOUT is stable while VOUT=1 and RDY_IN=0.
  - RDY_IN may toggle freely.
  - VOUT never depends combinationally on RDY_IN.
- Overflow:
  - On drop, OVF <= 1 and DROP_CNT increments, saturating at 2^CW-1.
  - The dropped sample is discarded; FIFO contents are untouched.
  - On CLR_OVF, OVF <= 0 and DROP_CNT <= 0.
  - If CLR_OVF and drop occur in the same cycle, the set wins: OVF=1, DROP_CNT=1.
- Arithmetic: samples are passed bit-exact with no modification.

Optional Feature:
- Macro FIR_OUT_PEAK_EN.
- When defined:
  - Adds output PEAK (DW bits, unsigned), the maximum |sample| over all pushed samples.
  - |-2^(DW-1)| saturates to 2^(DW-1)-1.
  - Update is registered on push.
  - Cleared by RST and by CLR_OVF. If CLR_OVF and push occur together, PEAK = |DIN| of that push.
- When not defined: the PEAK port and its logic are absent; all other behaviour is identical.

Test Plan (DEPTH=8, CW=8):
- Reset check: hold RST=1 with VIN=1 -> VOUT=0, DOUT=0, LEVEL=0, EMPTY=1, OVF=0.
- Pass-through: RDY_IN=1; push 0x0001, 0x7FFF, 0x8000 on consecutive cycles -> the same values appear on DOUT one per cycle with VOUT=1, and LEVEL never exceeds 1.
- Backpressure and fill:
  - RDY_IN=0; push 10 samples 1..10 -> FULL after the 8th, OVF=1, DROP_CNT=2.
  - Then RDY_IN=1 -> DOUT sequence 1..8, then EMPTY=1, and samples 9 and 10 never appear.
- Full with simultaneous push and pop: at LEVEL=8, VIN=1 with DIN=0x00AA and RDY_IN=1 -> no drop, LEVEL stays 8, and 0x00AA is read last after the wrap.
- Clear priority: CLR_OVF=1 in the same cycle as a drop -> OVF=1, DROP_CNT=1. Next cycle, CLR_OVF=1 with no drop -> OVF=0, DROP_CNT=0.
- Reset mid-stream: RST pulse at LEVEL=5 -> all outputs return to reset values immediately, and the next push of 0x1234 appears on DOUT. With FIR_OUT_PEAK_EN, pushing 0x8000 then 0x0005 -> PEAK=0x7FFF.

Source files
------------

// File: rtl/fir_out_buffer.sv
// First-word-fall-through output buffer behind the 4-tap FIR, with a valid/ready consumer
// port and a sticky overflow/drop counter. Optional PEAK magnitude tracker under FIR_OUT_PEAK_EN.
module fir_out_buffer #(
    parameter int DW    = 16,
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int CW    = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [DW-1:0] DIN,
    input  logic          VIN,
    output logic [DW-1:0] DOUT,
    output logic          VOUT,
    input  logic          RDY_IN,
    input  logic          CLR_OVF,
    output logic          FULL,
    output logic          EMPTY,
    output logic [AW:0]   LEVEL,
    output logic          OVF,
    output logic [CW-1:0] DROP_CNT
`ifdef FIR_OUT_PEAK_EN
    ,
    output logic [DW-1:0] PEAK
`endif
);

    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [AW:0]   r_level;
    logic          r_ovf;
    logic [CW-1:0] r_dropCnt;

    logic w_pop;
    logic w_push;
    logic w_drop;

    always_comb begin
        FULL     = (r_level == FULL_LEVEL);
        EMPTY    = (r_level == '0);
        VOUT     = ~EMPTY;
        DOUT     = VOUT ? r_mem[r_rdPtr] : '0;
        LEVEL    = r_level;
        OVF      = r_ovf;
        DROP_CNT = r_dropCnt;
        w_pop    = VOUT & RDY_IN;
        // A pop in the same cycle frees a slot, so a full buffer can still accept.
        w_push   = VIN & (~FULL | w_pop);
        w_drop   = VIN & FULL & ~w_pop;
    end

    // Storage is not reset; reads are gated by VOUT so stale contents never leak out.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= DIN;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + (AW+1)'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - (AW+1)'(1);
            end
        end
    end

    // A drop in the same cycle as a clear wins, restarting the count at one.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ovf     <= 1'b0;
            r_dropCnt <= '0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
            if (CLR_OVF) begin
                r_dropCnt <= CW'(1);
            end else if (r_dropCnt != '1) begin
                r_dropCnt <= r_dropCnt + CW'(1);
            end
        end else if (CLR_OVF) begin
            r_ovf     <= 1'b0;
            r_dropCnt <= '0;
        end
    end

`ifdef FIR_OUT_PEAK_EN
    localparam logic [DW-1:0] MIN_NEG = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] MAX_POS = {1'b0, {(DW-1){1'b1}}};

    logic [DW-1:0] r_peak;
    logic [DW-1:0] w_abs;

    // The most negative sample has no positive counterpart, so it saturates.
    always_comb begin
        if (!DIN[DW-1]) begin
            w_abs = DIN;
        end else if (DIN == MIN_NEG) begin
            w_abs = MAX_POS;
        end else begin
            w_abs = -DIN;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_peak <= '0;
        end else if (w_push) begin
            if (CLR_OVF || (w_abs > r_peak)) begin
                r_peak <= w_abs;
            end
        end else if (CLR_OVF) begin
            r_peak <= '0;
        end
    end

    assign PEAK = r_peak;
`endif

endmodule

// File: tb/tb_fir_out_buffer.sv
// Self-checking bench for fir_out_buffer: table-driven per-cycle vectors plus hand-written
// sequences for wrap-around, clear priority and mid-stream reset.
module tb_fir_out_buffer;

    logic        CLK;
    logic        RST;
    logic [15:0] DIN;
    logic        VIN;
    logic [15:0] DOUT;
    logic        VOUT;
    logic        RDY_IN;
    logic        CLR_OVF;
    logic        FULL;
    logic        EMPTY;
    logic [3:0]  LEVEL;
    logic        OVF;
    logic [7:0]  DROP_CNT;
`ifdef FIR_OUT_PEAK_EN
    logic [15:0] PEAK;
`endif

    int compCount = 0;
    int failCount = 0;

    typedef struct {
        logic        vin;
        logic [15:0] din;
        logic        rdy;
        logic        clr;
        logic        vout;
        logic [15:0] dout;
        logic [3:0]  level;
        logic        full;
        logic        ovf;
        logic [7:0]  drop;
    } vec_t;

    vec_t vecs[$];

    fir_out_buffer #(.DW(16), .DEPTH(8), .AW(3), .CW(8)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .DIN      (DIN),
        .VIN      (VIN),
        .DOUT     (DOUT),
        .VOUT     (VOUT),
        .RDY_IN   (RDY_IN),
        .CLR_OVF  (CLR_OVF),
        .FULL     (FULL),
        .EMPTY    (EMPTY),
        .LEVEL    (LEVEL),
        .OVF      (OVF),
        .DROP_CNT (DROP_CNT)
`ifdef FIR_OUT_PEAK_EN
        ,
        .PEAK     (PEAK)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the clock edge.
    task automatic applyStimulus(input logic vin, input logic [15:0] din,
                                 input logic rdy, input logic clr);
        VIN     = vin;
        DIN     = din;
        RDY_IN  = rdy;
        CLR_OVF = clr;
        @(posedge CLK);
        #1;
    endtask

    task automatic checkVec(input vec_t v, input int idx);
        checkOutput($sformatf("vec%0d.vout", idx), 32'(VOUT), 32'(v.vout));
        checkOutput($sformatf("vec%0d.dout", idx), 32'(DOUT), 32'(v.dout));
        checkOutput($sformatf("vec%0d.level", idx), 32'(LEVEL), 32'(v.level));
        checkOutput($sformatf("vec%0d.empty", idx), 32'(EMPTY), 32'(v.level == 4'd0));
        checkOutput($sformatf("vec%0d.full", idx), 32'(FULL), 32'(v.full));
        checkOutput($sformatf("vec%0d.ovf", idx), 32'(OVF), 32'(v.ovf));
        checkOutput($sformatf("vec%0d.drop", idx), 32'(DROP_CNT), 32'(v.drop));
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".vout"}, 32'(VOUT), 32'd0);
        checkOutput({tag, ".dout"}, 32'(DOUT), 32'd0);
        checkOutput({tag, ".level"}, 32'(LEVEL), 32'd0);
        checkOutput({tag, ".empty"}, 32'(EMPTY), 32'd1);
        checkOutput({tag, ".full"}, 32'(FULL), 32'd0);
        checkOutput({tag, ".ovf"}, 32'(OVF), 32'd0);
        checkOutput({tag, ".drop"}, 32'(DROP_CNT), 32'd0);
`ifdef FIR_OUT_PEAK_EN
        checkOutput({tag, ".peak"}, 32'(PEAK), 32'd0);
`endif
    endtask

    initial begin
        logic [15:0] drainExp [8];

        // Reset held with VIN active: nothing may be captured.
        RST = 1'b1; VIN = 1'b1; DIN = 16'h5555; RDY_IN = 1'b0; CLR_OVF = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        checkResetState("reset");
        VIN = 1'b0;
        RST = 1'b0;

        // Pass-through with consumer always ready.
        vecs.push_back('{1'b1, 16'h0001, 1'b1, 1'b0, 1'b1, 16'h0001, 4'd1, 1'b0, 1'b0, 8'd0});
        vecs.push_back('{1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b1, 16'h7FFF, 4'd1, 1'b0, 1'b0, 8'd0});
        vecs.push_back('{1'b1, 16'h8000, 1'b1, 1'b0, 1'b1, 16'h8000, 4'd1, 1'b0, 1'b0, 8'd0});
        vecs.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, 8'd0});
        // Backpressure fill with 1..10; 9 and 10 are dropped.
        for (int k = 1; k <= 10; k++) begin
            vecs.push_back('{1'b1, 16'(k), 1'b0, 1'b0, 1'b1, 16'h0001,
                             4'(k > 8 ? 8 : k), (k >= 8), (k > 8), 8'(k > 8 ? k - 8 : 0)});
        end
        // Drain: after pop k the head is k+1, until empty.
        for (int k = 1; k <= 8; k++) begin
            vecs.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, (k < 8), 16'(k < 8 ? k + 1 : 0),
                             4'(8 - k), 1'b0, 1'b1, 8'd2});
        end
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].vin, vecs[i].din, vecs[i].rdy, vecs[i].clr);
            checkVec(vecs[i], i);
        end

        // Clear with no drop, then fill and push/pop simultaneously while full.
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
        checkOutput("clr.ovf", 32'(OVF), 32'd0);
        checkOutput("clr.drop", 32'(DROP_CNT), 32'd0);
        for (int k = 0; k < 8; k++) applyStimulus(1'b1, 16'h0021 + 16'(k), 1'b0, 1'b0);
        checkOutput("fill2.full", 32'(FULL), 32'd1);
        checkOutput("fill2.level", 32'(LEVEL), 32'd8);
        applyStimulus(1'b1, 16'h00AA, 1'b1, 1'b0);
        checkOutput("fullpp.level", 32'(LEVEL), 32'd8);
        checkOutput("fullpp.ovf", 32'(OVF), 32'd0);
        checkOutput("fullpp.drop", 32'(DROP_CNT), 32'd0);
        for (int k = 0; k < 7; k++) drainExp[k] = 16'h0022 + 16'(k);
        drainExp[7] = 16'h00AA;
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("wrap.dout%0d", k), 32'(DOUT), 32'(drainExp[k]));
            applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        end
        checkOutput("wrap.empty", 32'(EMPTY), 32'd1);

        // Clear priority: drop and clear in the same cycle leaves a count of one.
        for (int k = 0; k < 10; k++) applyStimulus(1'b1, 16'h0100 + 16'(k), 1'b0, 1'b0);
        checkOutput("prio.drop_before", 32'(DROP_CNT), 32'd2);
        applyStimulus(1'b1, 16'h0BAD, 1'b0, 1'b1);
        checkOutput("prio.ovf_set", 32'(OVF), 32'd1);
        checkOutput("prio.drop_one", 32'(DROP_CNT), 32'd1);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
        checkOutput("prio.ovf_clr", 32'(OVF), 32'd0);
        checkOutput("prio.drop_clr", 32'(DROP_CNT), 32'd0);
        checkOutput("prio.head", 32'(DOUT), 32'h0100);

        // Mid-stream reset at LEVEL=5 with OVF set.
        applyStimulus(1'b1, 16'h0EEE, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        checkOutput("mid.level", 32'(LEVEL), 32'd5);
        checkOutput("mid.ovf", 32'(OVF), 32'd1);
        RDY_IN = 1'b0;
        #2 RST = 1'b1;
        #1;
        checkResetState("midreset");
        @(posedge CLK);
        #1 RST = 1'b0;
        applyStimulus(1'b1, 16'h1234, 1'b0, 1'b0);
        checkOutput("post.vout", 32'(VOUT), 32'd1);
        checkOutput("post.dout", 32'(DOUT), 32'h1234);
        checkOutput("post.level", 32'(LEVEL), 32'd1);
`ifdef FIR_OUT_PEAK_EN
        checkOutput("peak.first", 32'(PEAK), 32'h1234);
        applyStimulus(1'b1, 16'h8000, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0005, 1'b0, 1'b0);
        checkOutput("peak.sat", 32'(PEAK), 32'h7FFF);
        applyStimulus(1'b1, 16'hFFFD, 1'b0, 1'b1);
        checkOutput("peak.clrpush", 32'(PEAK), 32'h0003);
`endif
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
        $finish;
    end

endmodule
